// File: rtl/product_serializer.sv
// product_serializer
//   Drain end of the product register array. Takes a full DIM_C x DIM_A snapshot
//   of products in a single cycle, then streams the elements out in row-major order
//   over a valid/ready handshake, one element per accepted beat.
module product_serializer #(
    parameter int DIM_C     = 4,
    parameter int DIM_A     = 4,
    parameter int ACC_WIDTH = 16,
    localparam int CW       = (DIM_C > 1) ? $clog2(DIM_C) : 1,
    localparam int AW       = (DIM_A > 1) ? $clog2(DIM_A) : 1
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               load_valid,
    output logic                               load_ready,
    input  logic [DIM_C*DIM_A*ACC_WIDTH-1:0]   in_prod,
    input  logic                               abort,
    output logic                               out_valid,
    input  logic                               out_ready,
    output logic [ACC_WIDTH-1:0]               out_data,
    output logic [CW-1:0]                      out_c,
    output logic [AW-1:0]                      out_a,
    output logic                               out_last,
    output logic                               done
);

    typedef enum logic {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } state_e;

    typedef logic [DIM_C-1:0][DIM_A-1:0][ACC_WIDTH-1:0] snap_t;

    localparam logic [CW-1:0] C_LAST = CW'(DIM_C - 1);
    localparam logic [AW-1:0] A_LAST = AW'(DIM_A - 1);

    state_e          state_q, state_d;
    logic [CW-1:0]   c_idx_q, c_idx_d;
    logic [AW-1:0]   a_idx_q, a_idx_d;
    logic            done_q,  done_d;
    snap_t           snap_q;
    snap_t           in_arr;

    logic            load_fire;
    logic            beat;
    logic            at_last;

    // View the flat product bus as the [c][a] element array it carries.
    assign in_arr    = in_prod;

    // A snapshot is taken only from IDLE and only when no flush is requested.
    assign load_fire = (state_q == IDLE) && load_valid && !abort;
    assign beat      = (state_q == STREAM) && out_ready;
    assign at_last   = (c_idx_q == C_LAST) && (a_idx_q == A_LAST);

    // State register.
    // NOTE: clocked blocks use non-blocking assignments so every flop samples
    // pre-edge values regardless of block ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: abort wins over both a load and a final beat.
    // NOTE: each combinational block assigns its outputs a default first so no
    // path leaves a variable unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (load_fire) begin
                    state_d = STREAM;
                end
            end
            STREAM: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (beat && at_last) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Row-major index advance and completion pulse generation.
    always_comb begin
        c_idx_d = c_idx_q;
        a_idx_d = a_idx_q;
        done_d  = 1'b0;
        if (abort || load_fire) begin
            c_idx_d = '0;
            a_idx_d = '0;
        end else if (beat) begin
            if (a_idx_q == A_LAST) begin
                a_idx_d = '0;
                c_idx_d = (c_idx_q == C_LAST) ? '0 : c_idx_q + CW'(1);
            end else begin
                a_idx_d = a_idx_q + AW'(1);
            end
            done_d = at_last;
        end
    end

    // Index, done and snapshot registers.
    // NOTE: the snapshot buffer is reset along with the control flops so that
    // out_data reads zero after reset; it is otherwise only written on a load.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            c_idx_q <= '0;
            a_idx_q <= '0;
            done_q  <= 1'b0;
            snap_q  <= '0;
        end else begin
            c_idx_q <= c_idx_d;
            a_idx_q <= a_idx_d;
            done_q  <= done_d;
            if (load_fire) begin
                snap_q <= in_arr;
            end
        end
    end

    // Output decode: everything derives from the state and registered indices.
    always_comb begin
        load_ready = (state_q == IDLE);
        out_valid  = (state_q == STREAM);
        out_last   = (state_q == STREAM) && at_last;
        out_c      = c_idx_q;
        out_a      = a_idx_q;
        done       = done_q;
        out_data   = '0;
        for (int c = 0; c < DIM_C; c++) begin
            for (int a = 0; a < DIM_A; a++) begin
                if ((c_idx_q == CW'(c)) && (a_idx_q == AW'(a))) begin
                    out_data = snap_q[c][a];
                end
            end
        end
    end

endmodule
